// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF evaluation controller.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ARM    = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_RELAX  = 3'd5,
        ST_DONE   = 3'd6
    } puf_state_e;

    localparam logic [31:0] PUF_LFSR_TAPS  = 32'h8020_0003;
    localparam int          PUF_MIN_SETTLE = 3;

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer for the asynchronous arbiter output.
module puf_sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/puf_eval_ctrl.sv
// Sequences RESP_W arbiter-PUF evaluations over an LFSR-expanded challenge
// and hands the assembled response word out on a valid/ready handshake.
module puf_eval_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int                CHAL_W     = 32,
    parameter int                RESP_W     = 16,
    parameter int                SETTLE_CYC = 8,
    parameter logic [CHAL_W-1:0] LFSR_TAPS  = CHAL_W'(PUF_LFSR_TAPS)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [CHAL_W-1:0] challenge_i,
    output logic              busy_o,
    output logic [CHAL_W-1:0] chal_sel_o,
    output logic              launch_o,
    input  logic              arb_resp_i,
    output logic [RESP_W-1:0] resp_o,
    output logic              resp_valid_o,
    input  logic              resp_ready_i
);

    localparam int CNT_W = $clog2(SETTLE_CYC);
    localparam int BIT_W = $clog2(RESP_W + 1);

    if (SETTLE_CYC < PUF_MIN_SETTLE) begin : g_bad_settle
        $error("puf_eval_ctrl: SETTLE_CYC must be at least 3");
    end

    puf_state_e        r_state;
    puf_state_e        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [CHAL_W-1:0] r_chal_q;
    logic [CHAL_W-1:0] r_chal_sel;
    logic [RESP_W-1:0] r_resp;
    logic              w_sync;
    logic              w_settle_last;
    logic              w_last_bit;
    logic              w_active;
    logic [CHAL_W-1:0] w_chal_step;

    puf_sync2 u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (arb_resp_i),
        .o_q   (w_sync)
    );

    assign w_settle_last = (r_cnt == CNT_W'(SETTLE_CYC - 1));
    assign w_last_bit    = (r_bit == BIT_W'(RESP_W - 1));
    assign w_active      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    // Galois step; an all-zero seed is a fixed point and is allowed.
    assign w_chal_step   = r_chal_q[0] ? ((r_chal_q >> 1) ^ LFSR_TAPS) : (r_chal_q >> 1);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_i && !abort_i) w_next = ST_LOAD;
            ST_LOAD:   w_next = ST_ARM;
            ST_ARM:    w_next = ST_LAUNCH;
            ST_LAUNCH: if (w_settle_last) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_RELAX;
            ST_RELAX:  if (w_settle_last) w_next = w_last_bit ? ST_DONE : ST_ARM;
            ST_DONE:   if (resp_ready_i) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
        if (abort_i && w_active) w_next = ST_IDLE;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_chal_q   <= '0;
            r_chal_sel <= '0;
            r_resp     <= '0;
        end else begin
            if (w_next != r_state) r_cnt <= '0;
            else if (r_state == ST_LAUNCH || r_state == ST_RELAX) r_cnt <= r_cnt + 1'b1;

            if (r_state == ST_IDLE && w_next == ST_LOAD) begin
                r_chal_q <= challenge_i;
                r_resp   <= '0;
                r_bit    <= '0;
            end
            if (r_state == ST_SAMPLE) r_resp <= {r_resp[RESP_W-2:0], w_sync};
            if (r_state == ST_RELAX && w_settle_last) begin
                r_chal_q <= w_chal_step;
                r_bit    <= r_bit + 1'b1;
            end

            // Selects move only on ARM entry so they are settled before launch.
            if (w_next == ST_IDLE) r_chal_sel <= '0;
            else if (w_next == ST_ARM)
                r_chal_sel <= (r_state == ST_RELAX) ? w_chal_step : r_chal_q;
        end
    end

    always_comb begin
        launch_o     = (r_state == ST_LAUNCH) || (r_state == ST_SAMPLE);
        busy_o       = (r_state != ST_IDLE);
        resp_valid_o = (r_state == ST_DONE);
    end

    assign chal_sel_o = r_chal_sel;
    assign resp_o     = r_resp;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: per-bit arbiter patterns, latency, select sequencing, abort and reset.
module tb_puf_eval_ctrl;

    localparam int CHAL_W = 32;
    localparam int RESP_W = 16;
    localparam int SETTLE = 8;
    localparam int LAT    = 1 + RESP_W * (2 * SETTLE + 2);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              arb = 1'b0;
    logic              ready = 1'b0;
    logic [CHAL_W-1:0] chal_in = '0;
    logic              busy_o;
    logic [CHAL_W-1:0] chal_sel_o;
    logic              launch_o;
    logic [RESP_W-1:0] resp_o;
    logic              resp_valid_o;

    int checks = 0;
    int failures = 0;

    logic [RESP_W-1:0] sb_q[$];
    logic [CHAL_W-1:0] sel_log[$];
    int lat, runs, bad_runs, sel_in_launch;

    puf_eval_ctrl #(.CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYC(SETTLE)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .start_i      (start),
        .abort_i      (abort),
        .challenge_i  (chal_in),
        .busy_o       (busy_o),
        .chal_sel_o   (chal_sel_o),
        .launch_o     (launch_o),
        .arb_resp_i   (arb),
        .resp_o       (resp_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return c[0] ? ((c >> 1) ^ 32'h8020_0003) : (c >> 1);
    endfunction

    // Starts one evaluation and records what the chain sees until resp_valid_o or a 400-cycle bound.
    task automatic drive_eval(input logic [CHAL_W-1:0] seed, input logic [RESP_W-1:0] pat);
        logic [CHAL_W-1:0] prev;
        int cur;
        bit prev_l;
        sel_log.delete();
        runs = 0; bad_runs = 0; sel_in_launch = 0; cur = 0; prev_l = 1'b0;
        prev = chal_sel_o;
        chal_in = seed;
        arb = pat[RESP_W-1];
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (!resp_valid_o && lat < 400) begin
            step();
            lat++;
            if (chal_sel_o !== prev) begin
                sel_log.push_back(chal_sel_o);
                if (launch_o) sel_in_launch++;
                prev = chal_sel_o;
            end
            if (launch_o) cur++;
            else if (prev_l) begin
                runs++;
                if (cur != SETTLE + 1) bad_runs++;
                cur = 0;
            end
            prev_l = launch_o;
            arb = (runs < RESP_W) ? pat[RESP_W-1-runs] : 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_o, launch_o, resp_valid_o} !== 3'b000 || chal_sel_o !== '0 || resp_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b launch=%b valid=%b sel=%h resp=%h expected all zero",
                     busy_o, launch_o, resp_valid_o, chal_sel_o, resp_o);
        end
        #2 rst = 1'b0;
        repeat (3) step();
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle busy=%b expected 0", busy_o);
        end
    endtask

    task automatic test_basic();
        logic [CHAL_W-1:0] exp_sel;
        logic [RESP_W-1:0] exp;
        int sel_bad;
        ready = 1'b1;
        sb_q.push_back(16'hFFFF);
        drive_eval(32'h0000_0001, 16'hFFFF);
        checks++;
        if (lat !== LAT) begin
            failures++; $display("FAIL basic_latency got=%0d expected=%0d", lat, LAT);
        end
        checks++;
        if (runs !== RESP_W || bad_runs !== 0) begin
            failures++; $display("FAIL basic_launch_runs runs=%0d bad=%0d expected runs=16 bad=0", runs, bad_runs);
        end
        checks++;
        if (sel_log.size() != RESP_W || sel_in_launch != 0) begin
            failures++; $display("FAIL basic_sel_changes n=%0d in_launch=%0d expected 16/0", sel_log.size(), sel_in_launch);
        end else begin
            checks++;
            if (sel_log[0] !== 32'h0000_0001 || sel_log[1] !== 32'h8020_0003 || sel_log[2] !== 32'hC030_0002) begin
                failures++;
                $display("FAIL basic_sel_first3 got=%h %h %h expected 00000001 80200003 c0300002",
                         sel_log[0], sel_log[1], sel_log[2]);
            end
            exp_sel = 32'h0000_0001;
            sel_bad = 0;
            for (int i = 0; i < RESP_W; i++) begin
                if (sel_log[i] !== exp_sel) sel_bad++;
                exp_sel = lfsr_next(exp_sel);
            end
            checks++;
            if (sel_bad != 0) begin
                failures++; $display("FAIL basic_sel_sequence wrong_entries=%0d expected 0", sel_bad);
            end
        end
        exp = sb_q.pop_front();
        checks++;
        if (resp_o !== exp || resp_valid_o !== 1'b1) begin
            failures++; $display("FAIL basic_resp got=%h valid=%b expected=%h valid=1", resp_o, resp_valid_o, exp);
        end
        step();
        checks++;
        if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || chal_sel_o !== '0) begin
            failures++;
            $display("FAIL basic_handshake valid=%b busy=%b sel=%h expected 0/0/0", resp_valid_o, busy_o, chal_sel_o);
        end
    endtask

    task automatic test_patterns();
        logic [CHAL_W-1:0] seeds [4];
        logic [RESP_W-1:0] pats  [4];
        logic [RESP_W-1:0] exp;
        seeds = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0000, 32'h1357_9BDF};
        pats  = '{16'h8000, 16'hA5C3, 16'h0001, 16'h0000};
        ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sb_q.push_back(pats[t]);
            drive_eval(seeds[t], pats[t]);
            exp = sb_q.pop_front();
            checks++;
            if (resp_o !== exp || lat !== LAT) begin
                failures++;
                $display("FAIL pattern_%0d resp=%h lat=%0d expected resp=%h lat=%0d", t, resp_o, lat, exp, LAT);
            end
            if (seeds[t] == '0) begin
                checks++;
                if (sel_log.size() != 0) begin
                    failures++; $display("FAIL zero_chal_sel changes=%0d expected 0", sel_log.size());
                end
            end
            step();
        end
    endtask

    task automatic test_hold();
        logic [RESP_W-1:0] exp;
        int bad;
        ready = 1'b0;
        sb_q.push_back(16'h3C5A);
        drive_eval(32'hCAFE_0123, 16'h3C5A);
        exp = sb_q.pop_front();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            step();
            if (resp_valid_o !== 1'b1 || resp_o !== exp || busy_o !== 1'b1) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL hold_stable bad_cycles=%0d resp=%h expected 0 bad and resp=%h", bad, resp_o, exp);
        end
        ready = 1'b1;
        step();
        checks++;
        if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL hold_release valid=%b busy=%b expected 0/0", resp_valid_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [RESP_W-1:0] exp;
        ready = 1'b0;
        sb_q.push_back(16'h1234);
        drive_eval(32'h0BAD_F00D, 16'h1234);
        exp = sb_q.pop_front();
        checks++;
        if (resp_o !== exp) begin
            failures++; $display("FAIL b2b_first resp=%h expected=%h", resp_o, exp);
        end
        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            failures++; $display("FAIL b2b_start_in_done busy=%b valid=%b expected 0/0", busy_o, resp_valid_o);
        end
        sb_q.push_back(16'hFEDC);
        drive_eval(32'h0BAD_F00D, 16'hFEDC);
        exp = sb_q.pop_front();
        checks++;
        if (resp_o !== exp || lat !== LAT) begin
            failures++; $display("FAIL b2b_second resp=%h lat=%0d expected resp=%h lat=%0d", resp_o, lat, exp, LAT);
        end
        step();
    endtask

    task automatic test_abort();
        int seen;
        logic [RESP_W-1:0] exp;
        ready = 1'b1;
        chal_in = 32'h1234_5679;
        start = 1'b1;
        step();
        start = 1'b0;
        // bit 5 LAUNCH spans edges 92..99 after the accepting edge
        repeat (93) step();
        checks++;
        if (launch_o !== 1'b1 || busy_o !== 1'b1) begin
            failures++; $display("FAIL abort_pre launch=%b busy=%b expected 1/1", launch_o, busy_o);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (launch_o !== 1'b0 || busy_o !== 1'b0 || chal_sel_o !== '0) begin
            failures++; $display("FAIL abort_post launch=%b busy=%b sel=%h expected 0/0/0", launch_o, busy_o, chal_sel_o);
        end
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (resp_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++; $display("FAIL abort_no_valid active_cycles=%0d expected 0", seen);
        end
        sb_q.push_back(16'h0F0F);
        drive_eval(32'h1234_5679, 16'h0F0F);
        exp = sb_q.pop_front();
        checks++;
        if (resp_o !== exp || lat !== LAT) begin
            failures++; $display("FAIL abort_restart resp=%h lat=%0d expected resp=%h lat=%0d", resp_o, lat, exp, LAT);
        end
        step();
    endtask

    task automatic test_async_reset();
        chal_in = 32'h0000_0001;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        checks++;
        if (launch_o !== 1'b1 || chal_sel_o !== 32'h0000_0001) begin
            failures++; $display("FAIL arst_pre launch=%b sel=%h expected 1/00000001", launch_o, chal_sel_o);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (launch_o !== 1'b0 || busy_o !== 1'b0 || chal_sel_o !== '0) begin
            failures++; $display("FAIL arst_immediate launch=%b busy=%b sel=%h expected 0/0/0", launch_o, busy_o, chal_sel_o);
        end
        #2 rst = 1'b0;
        repeat (5) step();
        checks++;
        if (busy_o !== 1'b0 || launch_o !== 1'b0 || resp_valid_o !== 1'b0 || chal_sel_o !== '0) begin
            failures++;
            $display("FAIL arst_idle busy=%b launch=%b valid=%b sel=%h expected all 0", busy_o, launch_o, resp_valid_o, chal_sel_o);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_basic();
        test_patterns();
        test_hold();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
